// File: rtl/nibbler_pkg.sv
// Shared types for the Nibbler I/O port: the 4-bit data nibble.
package nibbler_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_fifo.sv
// Small synchronous nibble FIFO with occupancy count; head is read combinationally.
// A pop frees its slot on the same edge, so push is accepted when full if pop also fires.
module nibble_fifo
  import nibbler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  nibble_t          din,
  output nibble_t          dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  nibble_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/nibbler_io_port.sv
// Nibbler CPU I/O responder: IN reads drain the RX FIFO, OUT writes fill the TX FIFO.
// Define NIBBLER_IO_ERR_EN to get sticky err_ovf/err_udf flags; otherwise they tie to 0.
module nibbler_io_port
  import nibbler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fase,
  input  logic             notOeIN,
  input  logic             notLoadOut,
  input  nibble_t          cpu_wdata,
  output nibble_t          cpu_rdata,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  nibble_t          rx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output nibble_t          tx_data,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count,
  output logic             err_ovf,
  output logic             err_udf,
  input  logic             err_clr
);

  logic    rd_strobe, wr_strobe;
  logic    rx_push, rx_pop, rx_full, rx_empty;
  logic    tx_push, tx_pop, tx_full, tx_empty;
  nibble_t rx_head;

  // Strobes only count in the execute phase, so a strobe spanning both phases acts once.
  assign rd_strobe = fase & ~notOeIN;
  assign wr_strobe = fase & ~notLoadOut;

  assign rx_ready  = ~rx_full;
  assign rx_push   = rx_valid & rx_ready;
  assign rx_pop    = rd_strobe & ~rx_empty;
  assign cpu_rdata = rx_empty ? nibble_t'(0) : rx_head;

  assign tx_valid  = ~tx_empty;
  assign tx_pop    = tx_valid & tx_ready;
  assign tx_push   = wr_strobe & (~tx_full | tx_pop);

  nibble_fifo #(
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  nibble_fifo #(
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (cpu_wdata),
    .dout  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

`ifdef NIBBLER_IO_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  // A set event on the clearing edge wins over the clear.
  always_comb begin
    err_ovf_d = (wr_strobe & ~tx_push) | (err_ovf_q & ~err_clr);
    err_udf_d = (rd_strobe & rx_empty) | (err_udf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_ovf        = 1'b0;
  assign err_udf        = 1'b0;
`endif

endmodule
